rename_stage: RTL and testbench

RENAME_STAGE -- requirements
Module: rename_stage

---
 rtl/rename_pkg.sv | 73 +++++++
 rtl/rename_free_list.sv | 81 ++++++++
 rtl/rename_stage.sv | 167 ++++++++++++++++
 tb/tb_rename_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared sizes, types and free-list pointer helpers for the rename stage
//
// Purpose: register-file sizes, the physical register number type, the uOP in,
// renamed uOP out and commit entry structs, and the circular free-list pointer
// type with its wrap-aware add and occupancy helpers.
// Ports: none (package).
package rename_pkg;

    localparam int PRF_NUM  = 64;
    localparam int ARF_NUM  = 32;
    localparam int PRF_W    = $clog2(PRF_NUM);
    localparam int ARF_W    = $clog2(ARF_NUM);
    // Two slots beyond the free registers so a full pair of commits can push
    // before the matching committed-head advance is visible.
    localparam int FL_DEPTH = PRF_NUM - ARF_NUM + 2;
    localparam int FL_IDX_W = $clog2(FL_DEPTH);

    typedef logic [PRF_W-1:0] PRFNum;
    typedef logic [ARF_W-1:0] ARFNum;

    typedef struct packed {
        logic  valid;
        logic  wen;
        ARFNum rs0;
        ARFNum rs1;
        ARFNum rd;
    } uop_t;

    typedef struct packed {
        logic  valid;
        PRFNum prs0;
        PRFNum prs1;
        PRFNum prd;
        PRFNum old_prd;
    } renamed_uop_t;

    typedef struct packed {
        logic  valid;
        logic  wen;
        ARFNum ard;
        PRFNum prd;
        PRFNum old_prd;
    } commit_entry_t;

    // Pointer into a non-power-of-two ring; the wrap bit separates full from empty.
    typedef struct packed {
        logic                wrap;
        logic [FL_IDX_W-1:0] idx;
    } fl_ptr_t;

    function automatic fl_ptr_t fl_ptr_add(fl_ptr_t p, logic [1:0] n);
        logic [FL_IDX_W:0] sum;
        fl_ptr_t           r;
        sum = {1'b0, p.idx} + {{(FL_IDX_W-1){1'b0}}, n};
        r   = p;
        if (sum >= (FL_IDX_W+1)'(FL_DEPTH)) begin
            r.idx  = FL_IDX_W'(sum - (FL_IDX_W+1)'(FL_DEPTH));
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = sum[FL_IDX_W-1:0];
        end
        return r;
    endfunction

    // Number of entries from head up to (not including) tail.
    function automatic logic [FL_IDX_W:0] fl_count(fl_ptr_t tail, fl_ptr_t head);
        if (tail.wrap == head.wrap) begin
            return {1'b0, tail.idx} - {1'b0, head.idx};
        end
        return (FL_IDX_W+1)'(FL_DEPTH) - {1'b0, head.idx} + {1'b0, tail.idx};
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular physical-register free list with speculative and committed heads
//
// Purpose: hands out up to two free registers per cycle from the speculative
// head, accepts up to two released registers per cycle at the tail, tracks the
// committed head (advanced once per push) and restores the speculative head
// from it on flush.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   pop_cnt_i            registers consumed this cycle (0..2)
//   pop_data0/1_o        next and next-but-one free registers
//   push0/1_i, *_data_i  released registers, push0 lands first
//   flush_i              speculative head <= committed head (after this cycle's pushes)
//   free_count_o         tail - speculative head
module rename_free_list
    import rename_pkg::*;
#(
    parameter int PRF_NUM = rename_pkg::PRF_NUM,
    parameter int ARF_NUM = rename_pkg::ARF_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pop_cnt_i,
    output PRFNum             pop_data0_o,
    output PRFNum             pop_data1_o,
    input  logic              push0_i,
    input  PRFNum             push0_data_i,
    input  logic              push1_i,
    input  PRFNum             push1_data_i,
    input  logic              flush_i,
    output logic [FL_IDX_W:0] free_count_o
);

    PRFNum   mem_q [FL_DEPTH];
    fl_ptr_t head_q, chead_q, tail_q;
    fl_ptr_t head_d, chead_d, tail_d;
    fl_ptr_t head_p1, tail_p1;
    logic [1:0] push_cnt;
    logic       wr_en0, wr_en1;
    PRFNum      wr_data0, wr_data1;

    always_comb begin
        push_cnt = 2'(push0_i) + 2'(push1_i);
        head_p1  = fl_ptr_add(head_q, 2'd1);
        tail_p1  = fl_ptr_add(tail_q, 2'd1);
        // Every push is a committed allocation, so the committed head moves in step.
        chead_d  = fl_ptr_add(chead_q, push_cnt);
        tail_d   = fl_ptr_add(tail_q, push_cnt);
        head_d   = flush_i ? chead_d : fl_ptr_add(head_q, pop_cnt_i);
        // Pack the active pushes onto consecutive slots starting at tail.
        wr_en0   = push0_i | push1_i;
        wr_data0 = push0_i ? push0_data_i : push1_data_i;
        wr_en1   = push0_i & push1_i;
        wr_data1 = push1_data_i;
    end

    assign pop_data0_o  = mem_q[head_q.idx];
    assign pop_data1_o  = mem_q[head_p1.idx];
    assign free_count_o = fl_count(tail_q, head_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= (i < PRF_NUM - ARF_NUM) ? PRFNum'(ARF_NUM + i) : '0;
            end
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= '{wrap: 1'b0, idx: FL_IDX_W'(PRF_NUM - ARF_NUM)};
        end else begin
            if (wr_en0) mem_q[tail_q.idx]  <= wr_data0;
            if (wr_en1) mem_q[tail_p1.idx] <= wr_data1;
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
        end
    end

    // Pushes may only fill slots already released by the committed head.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (int'(fl_count(tail_q, chead_q)) + int'(push_cnt) <= FL_DEPTH));

endmodule

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - two-wide register rename stage with speculative/committed RAT recovery
//
// Purpose: renames two uOPs per cycle (uop0 older) through a speculative RAT,
// bypassing uop0's destination into uop1, allocating from rename_free_list,
// and recovering the RAT from the committed RAT on flush. Commits update the
// committed RAT and release old mappings every cycle.
// Optional: RENAME_PERF_CNT_EN adds saturating stall_cycles_o / renamed_uops_o.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pause_i, flush_i         pipeline control in (flush beats pause beats stall)
//   pause_req_o              combinational: bundle needs more registers than are free
//   uop0_i, uop1_i           decoded uOPs in
//   ren0_o, ren1_o           registered renamed uOPs out
//   commit0_i, commit1_i     commits, commit1 applied after commit0
module rename_stage
    import rename_pkg::*;
#(
    parameter int PRF_NUM = rename_pkg::PRF_NUM,
    parameter int ARF_NUM = rename_pkg::ARF_NUM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pause_i,
    input  logic          flush_i,
    output logic          pause_req_o,
    input  uop_t          uop0_i,
    input  uop_t          uop1_i,
    output renamed_uop_t  ren0_o,
    output renamed_uop_t  ren1_o,
`ifdef RENAME_PERF_CNT_EN
    output logic [31:0]   stall_cycles_o,
    output logic [31:0]   renamed_uops_o,
`endif
    input  commit_entry_t commit0_i,
    input  commit_entry_t commit1_i
);

    PRFNum rat_q  [ARF_NUM];
    PRFNum rat_d  [ARF_NUM];
    PRFNum crat_q [ARF_NUM];
    PRFNum crat_d [ARF_NUM];

    renamed_uop_t ren0_q, ren0_d, ren1_q, ren1_d;

    logic              alloc0, alloc1, cmt0, cmt1;
    logic              stall, accept;
    logic [1:0]        need, pop_cnt;
    logic [FL_IDX_W:0] free_count;
    PRFNum             pop_data0, pop_data1, prd0, prd1;

    assign alloc0  = uop0_i.valid & uop0_i.wen & (uop0_i.rd != '0);
    assign alloc1  = uop1_i.valid & uop1_i.wen & (uop1_i.rd != '0);
    assign cmt0    = commit0_i.valid & commit0_i.wen & (commit0_i.ard != '0);
    assign cmt1    = commit1_i.valid & commit1_i.wen & (commit1_i.ard != '0);
    assign need    = 2'(alloc0) + 2'(alloc1);
    assign stall   = (FL_IDX_W+1)'(need) > free_count;
    assign accept  = ~flush_i & ~pause_i & ~stall;
    assign pop_cnt = accept ? need : 2'd0;

    assign pause_req_o = stall & ~rst;

    // uop1 takes the first free register only when uop0 did not allocate.
    assign prd0 = alloc0 ? pop_data0 : '0;
    assign prd1 = alloc1 ? (alloc0 ? pop_data1 : pop_data0) : '0;

    rename_free_list #(
        .PRF_NUM (PRF_NUM),
        .ARF_NUM (ARF_NUM)
    ) u_free_list (
        .clk          (clk),
        .rst          (rst),
        .pop_cnt_i    (pop_cnt),
        .pop_data0_o  (pop_data0),
        .pop_data1_o  (pop_data1),
        .push0_i      (cmt0),
        .push0_data_i (commit0_i.old_prd),
        .push1_i      (cmt1),
        .push1_data_i (commit1_i.old_prd),
        .flush_i      (flush_i),
        .free_count_o (free_count)
    );

    always_comb begin
        ren0_d = ren0_q;
        ren1_d = ren1_q;
        if (flush_i || (!pause_i && stall)) begin
            ren0_d = '0;
            ren1_d = '0;
        end else if (!pause_i) begin
            ren0_d = '0;
            if (uop0_i.valid) begin
                ren0_d.valid   = 1'b1;
                ren0_d.prs0    = rat_q[uop0_i.rs0];
                ren0_d.prs1    = rat_q[uop0_i.rs1];
                ren0_d.prd     = prd0;
                ren0_d.old_prd = alloc0 ? rat_q[uop0_i.rd] : '0;
            end
            ren1_d = '0;
            if (uop1_i.valid) begin
                ren1_d.valid   = 1'b1;
                ren1_d.prs0    = (alloc0 && uop1_i.rs0 == uop0_i.rd) ? prd0 : rat_q[uop1_i.rs0];
                ren1_d.prs1    = (alloc0 && uop1_i.rs1 == uop0_i.rd) ? prd0 : rat_q[uop1_i.rs1];
                ren1_d.prd     = prd1;
                ren1_d.old_prd = !alloc1                           ? '0   :
                                 (alloc0 && uop1_i.rd == uop0_i.rd) ? prd0 : rat_q[uop1_i.rd];
            end
        end
    end

    // Committed RAT first, so a flush restores state including this cycle's commits.
    always_comb begin
        crat_d = crat_q;
        if (cmt0) crat_d[commit0_i.ard] = commit0_i.prd;
        if (cmt1) crat_d[commit1_i.ard] = commit1_i.prd;
        rat_d = rat_q;
        if (flush_i) begin
            rat_d = crat_d;
        end else if (accept) begin
            if (alloc0) rat_d[uop0_i.rd] = prd0;
            if (alloc1) rat_d[uop1_i.rd] = prd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARF_NUM; i++) begin
                rat_q[i]  <= PRFNum'(i);
                crat_q[i] <= PRFNum'(i);
            end
            ren0_q <= '0;
            ren1_q <= '0;
        end else begin
            rat_q  <= rat_d;
            crat_q <= crat_d;
            ren0_q <= ren0_d;
            ren1_q <= ren1_d;
        end
    end

    assign ren0_o = ren0_q;
    assign ren1_o = ren1_q;

`ifdef RENAME_PERF_CNT_EN
    logic [31:0] stall_cycles_q, renamed_uops_q;
    logic [1:0]  n_ren;
    logic [32:0] ren_sum;

    assign n_ren   = accept ? (2'(uop0_i.valid) + 2'(uop1_i.valid)) : 2'd0;
    assign ren_sum = {1'b0, renamed_uops_q} + 33'(n_ren);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            renamed_uops_q <= '0;
        end else begin
            if (stall && !flush_i && !pause_i && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            renamed_uops_q <= ren_sum[32] ? '1 : ren_sum[31:0];
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign renamed_uops_o = renamed_uops_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - directed self-checking bench for rename_stage
module tb_rename_stage;
    import rename_pkg::*;

    logic          clk = 1'b0;
    logic          rst, pause, flush, pause_req;
    uop_t          uop0, uop1;
    renamed_uop_t  ren0, ren1, exp0, exp1;
    commit_entry_t c0, c1;
    int            checks = 0;
    int            errors = 0;
`ifdef RENAME_PERF_CNT_EN
    logic [31:0]   stall_cycles, renamed_uops;
`endif

    always #5 clk = ~clk;

    rename_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pause_i     (pause),
        .flush_i     (flush),
        .pause_req_o (pause_req),
        .uop0_i      (uop0),
        .uop1_i      (uop1),
        .ren0_o      (ren0),
        .ren1_o      (ren1),
`ifdef RENAME_PERF_CNT_EN
        .stall_cycles_o (stall_cycles),
        .renamed_uops_o (renamed_uops),
`endif
        .commit0_i   (c0),
        .commit1_i   (c1)
    );

    function automatic uop_t mk_uop(int v, int w, int rs0, int rs1, int rd);
        uop_t u;
        u.valid = v[0]; u.wen = w[0];
        u.rs0 = ARFNum'(rs0); u.rs1 = ARFNum'(rs1); u.rd = ARFNum'(rd);
        return u;
    endfunction

    function automatic renamed_uop_t mk_ren(int p0, int p1, int pd, int op);
        renamed_uop_t r;
        r.valid = 1'b1;
        r.prs0 = PRFNum'(p0); r.prs1 = PRFNum'(p1); r.prd = PRFNum'(pd); r.old_prd = PRFNum'(op);
        return r;
    endfunction

    function automatic commit_entry_t mk_cmt(int ard, int prd, int old_prd);
        commit_entry_t c;
        c.valid = 1'b1; c.wen = 1'b1;
        c.ard = ARFNum'(ard); c.prd = PRFNum'(prd); c.old_prd = PRFNum'(old_prd);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        uop0 = '0; uop1 = '0; c0 = '0; c1 = '0; pause = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ren0 !== '0) begin errors++; $display("FAIL reset ren0: got %h expected 0", ren0); end
        checks++; if (ren1 !== '0) begin errors++; $display("FAIL reset ren1: got %h expected 0", ren1); end
        checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL reset pause_req: got %b expected 0", pause_req); end
    endtask

    task automatic test_bypass();
        do_reset();
        uop0 = mk_uop(1, 1, 1, 2, 5);
        uop1 = mk_uop(1, 1, 5, 0, 6);
        step();
        clear_inputs();
        exp0 = mk_ren(1, 2, 32, 5);
        exp1 = mk_ren(32, 0, 33, 6);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL bypass ren0: got %h expected %h", ren0, exp0); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL bypass ren1: got %h expected %h", ren1, exp1); end
    endtask

    task automatic test_same_rd();
        do_reset();
        uop0 = mk_uop(1, 1, 0, 0, 7);
        uop1 = mk_uop(1, 1, 0, 0, 7);
        step();
        exp0 = mk_ren(0, 0, 32, 7);
        exp1 = mk_ren(0, 0, 33, 32);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL same_rd ren0: got %h expected %h", ren0, exp0); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL same_rd ren1: got %h expected %h", ren1, exp1); end
        // wen=0 and rd=0 allocate nothing and report zero mappings
        uop0 = mk_uop(1, 0, 7, 0, 7);
        uop1 = mk_uop(1, 1, 7, 0, 0);
        step();
        exp0 = mk_ren(33, 0, 0, 0);
        exp1 = mk_ren(33, 0, 0, 0);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL no_write ren0: got %h expected %h", ren0, exp0); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL rd_zero ren1: got %h expected %h", ren1, exp1); end
        uop0 = mk_uop(1, 1, 0, 0, 9);
        uop1 = '0;
        step();
        clear_inputs();
        exp0 = mk_ren(0, 0, 34, 9);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL no_pop ren0: got %h expected %h", ren0, exp0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        uop0 = mk_uop(1, 1, 0, 0, 1);
        uop1 = mk_uop(1, 1, 0, 0, 2);
        step();
        exp0 = mk_ren(0, 0, 32, 1);
        exp1 = mk_ren(0, 0, 33, 2);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL b2b_a ren0: got %h expected %h", ren0, exp0); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL b2b_a ren1: got %h expected %h", ren1, exp1); end
        uop0 = mk_uop(1, 1, 1, 0, 1);
        uop1 = mk_uop(1, 1, 2, 0, 3);
        step();
        exp0 = mk_ren(32, 0, 34, 32);
        exp1 = mk_ren(33, 0, 35, 3);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL b2b_b ren0: got %h expected %h", ren0, exp0); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL b2b_b ren1: got %h expected %h", ren1, exp1); end
        uop0 = '0;
        uop1 = mk_uop(1, 1, 0, 0, 4);
        step();
        clear_inputs();
        exp1 = mk_ren(0, 0, 36, 4);
        checks++; if (ren0.valid !== 1'b0) begin errors++; $display("FAIL b2b_c ren0.valid: got %b expected 0", ren0.valid); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL b2b_c ren1: got %h expected %h", ren1, exp1); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            uop0 = mk_uop(1, 1, 0, 0, (i % 31) + 1);
            step();
        end
        exp0 = mk_ren(0, 0, 63, 32);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL last_free ren0: got %h expected %h", ren0, exp0); end
        uop0 = mk_uop(1, 1, 0, 0, 10);
        uop1 = mk_uop(1, 1, 0, 0, 11);
        #1;
        checks++; if (pause_req !== 1'b1) begin errors++; $display("FAIL stall pause_req: got %b expected 1", pause_req); end
        step();
        checks++; if ({ren0.valid, ren1.valid} !== 2'b00) begin errors++; $display("FAIL stall valids: got %b expected 00", {ren0.valid, ren1.valid}); end
        c0 = mk_cmt(9, 40, 9);
        step();
        c0 = '0;
        checks++; if (pause_req !== 1'b1) begin errors++; $display("FAIL one_free pause_req: got %b expected 1", pause_req); end
        checks++; if ({ren0.valid, ren1.valid} !== 2'b00) begin errors++; $display("FAIL one_free valids: got %b expected 00", {ren0.valid, ren1.valid}); end
        c0 = mk_cmt(1, 32, 1);
        step();
        c0 = '0;
        checks++; if (pause_req !== 1'b0) begin errors++; $display("FAIL two_free pause_req: got %b expected 0", pause_req); end
        step();
        clear_inputs();
        exp0 = mk_ren(0, 0, 9, 41);
        exp1 = mk_ren(0, 0, 1, 42);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL unstall ren0: got %h expected %h", ren0, exp0); end
        checks++; if (ren1 !== exp1) begin errors++; $display("FAIL unstall ren1: got %h expected %h", ren1, exp1); end
    endtask

    task automatic test_flush_recover();
        do_reset();
        uop0 = mk_uop(1, 1, 0, 0, 3);
        uop1 = mk_uop(1, 1, 0, 0, 4);
        step();
        clear_inputs();
        c0 = mk_cmt(3, 32, 3);
        step();
        c0 = '0;
        flush = 1'b1;
        uop0 = mk_uop(1, 1, 0, 0, 13);
        step();
        clear_inputs();
        checks++; if (ren0.valid !== 1'b0) begin errors++; $display("FAIL flush ren0.valid: got %b expected 0", ren0.valid); end
        uop0 = mk_uop(1, 1, 4, 3, 12);
        step();
        clear_inputs();
        exp0 = mk_ren(4, 32, 33, 12);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL recover ren0: got %h expected %h", ren0, exp0); end
    endtask

    task automatic test_flush_commit();
        do_reset();
        c0 = mk_cmt(8, 40, 8);
        flush = 1'b1;
        uop0 = mk_uop(1, 1, 0, 0, 9);
        step();
        clear_inputs();
        checks++; if (ren0.valid !== 1'b0) begin errors++; $display("FAIL flush_cmt ren0.valid: got %b expected 0", ren0.valid); end
        uop0 = mk_uop(1, 1, 8, 9, 10);
        step();
        clear_inputs();
        exp0 = mk_ren(40, 9, 33, 10);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL flush_cmt ren0: got %h expected %h", ren0, exp0); end
    endtask

    task automatic test_dual_commit();
        do_reset();
        c0 = mk_cmt(5, 40, 5);
        c1 = mk_cmt(5, 41, 40);
        flush = 1'b1;
        step();
        clear_inputs();
        uop0 = mk_uop(1, 1, 5, 0, 6);
        step();
        clear_inputs();
        exp0 = mk_ren(41, 0, 34, 6);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL dual_cmt ren0: got %h expected %h", ren0, exp0); end
    endtask

    task automatic test_pause();
        do_reset();
        uop0 = mk_uop(1, 1, 0, 0, 2);
        step();
        exp0 = mk_ren(0, 0, 32, 2);
        uop0 = mk_uop(1, 1, 2, 0, 20);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ren0 !== exp0) begin errors++; $display("FAIL pause_hold%0d ren0: got %h expected %h", i, ren0, exp0); end
        end
        pause = 1'b0;
        step();
        exp0 = mk_ren(32, 0, 33, 20);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL pause_release ren0: got %h expected %h", ren0, exp0); end
        uop0 = mk_uop(1, 1, 20, 0, 21);
        step();
        clear_inputs();
        exp0 = mk_ren(33, 0, 34, 21);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL pause_once ren0: got %h expected %h", ren0, exp0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        uop0 = mk_uop(1, 1, 0, 0, 5);
        step();
        uop0 = mk_uop(1, 1, 0, 0, 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        checks++; if (ren0 !== '0) begin errors++; $display("FAIL mid_reset ren0: got %h expected 0", ren0); end
        uop0 = mk_uop(1, 1, 5, 6, 7);
        step();
        clear_inputs();
        exp0 = mk_ren(5, 6, 32, 7);
        checks++; if (ren0 !== exp0) begin errors++; $display("FAIL mid_reset rename: got %h expected %h", ren0, exp0); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_bypass();
        test_same_rd();
        test_back_to_back();
        test_stall();
        test_flush_recover();
        test_flush_commit();
        test_dual_commit();
        test_pause();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
